vga_timing_core: RTL and testbench

- Pixel-clock-driven raster timing generator for a 640x480 @ 60 Hz VGA display, running on the 25 MHz pixel clock.
- Produces horizontal and vertical sync, the active-video flag, and the current pixel coordinate used to address image and sprite RAMs.
- Produces a one-cycle end-of-frame pulse that drives per-frame game-state updates (sprite movement).
- Sits between the clock divider and the pixel colour mux in the display top level.

---
 rtl/vga_timing_core.sv | 113 +++++++++++
 tb/tb_vga_timing_core.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_core.sv
// Raster timing generator for a 640x480 @ 60 Hz display on the 25 MHz pixel clock.
// Two free-running counters (pixel within line, line within frame) are decoded
// combinationally into sync, active-video, end-of-frame and clamped pixel coordinates.
module vga_timing_core #(
  parameter int unsigned WIDTH    = 640,
  parameter int unsigned HEIGHT   = 480,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk25,
  input  logic       reset,
  output logic       hSync,
  output logic       vSync,
  output logic       active,
  output logic       screenEnd,
  output logic [9:0] x,
  output logic [8:0] y
);

  localparam int unsigned H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  // Decode boundaries, pre-sized to the counter widths.
  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END    = HW'(WIDTH);
  localparam logic [HW-1:0] H_SYNC_START = HW'(WIDTH + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(WIDTH + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_ONE        = HW'(1);

  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END    = VW'(HEIGHT);
  localparam logic [VW-1:0] V_SYNC_START = VW'(HEIGHT + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(HEIGHT + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_ONE        = VW'(1);

  // Coordinates are held at the last visible pixel during blanking so that
  // x + WIDTH*y never leaves the frame buffer.
  localparam logic [9:0] X_MAX = 10'(WIDTH - 1);
  localparam logic [8:0] Y_MAX = 9'(HEIGHT - 1);

  logic [HW-1:0] h_count_q, h_count_d;
  logic [VW-1:0] v_count_q, v_count_d;
  logic          h_wrap;
  logic          v_wrap;

  logic h_visible;
  logic v_visible;
  logic h_in_sync;
  logic v_in_sync;
  logic frame_end;

  // Next-state for the pixel and line counters; lines advance only on a line wrap.
  always_comb begin
    h_wrap    = (h_count_q == H_LAST);
    v_wrap    = (v_count_q == V_LAST);
    h_count_d = h_count_q + H_ONE;
    v_count_d = v_count_q;
    if (h_wrap) begin
      h_count_d = '0;
      if (v_wrap) begin
        v_count_d = '0;
      end else begin
        v_count_d = v_count_q + V_ONE;
      end
    end
  end

  // Counter registers; reset restarts the raster at pixel (0,0).
  always_ff @(posedge clk25) begin
    if (reset) begin
      h_count_q <= '0;
      v_count_q <= '0;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
    end
  end

  // Region decode of the current counter values.
  always_comb begin
    h_visible = (h_count_q < H_VIS_END);
    v_visible = (v_count_q < V_VIS_END);
    h_in_sync = (h_count_q >= H_SYNC_START) && (h_count_q < H_SYNC_END);
    v_in_sync = (v_count_q >= V_SYNC_START) && (v_count_q < V_SYNC_END);
    frame_end = (h_count_q == '0) && (v_count_q == V_VIS_END);
  end

  // Output decode; reset forces idle values so no partial sync pulse escapes.
  always_comb begin
    hSync     = ~SYNC_POL;
    vSync     = ~SYNC_POL;
    active    = 1'b0;
    screenEnd = 1'b0;
    x         = '0;
    y         = '0;
    if (!reset) begin
      hSync     = h_in_sync ? SYNC_POL : ~SYNC_POL;
      vSync     = v_in_sync ? SYNC_POL : ~SYNC_POL;
      active    = h_visible && v_visible;
      screenEnd = frame_end;
      x         = h_visible ? 10'(h_count_q) : X_MAX;
      y         = v_visible ? 9'(v_count_q) : Y_MAX;
    end
  end

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: a full-size instance for line timing, plus two
// reduced-geometry instances (both sync polarities) for frame-level behaviour,
// all checked every cycle against an arithmetic raster model.
`timescale 1ns/1ps
module tb_vga_timing_core;

  // Reduced geometry: 32 pixels per line, 21 lines per frame, 672 cycles per frame.
  localparam int unsigned S_W  = 20;
  localparam int unsigned S_H  = 12;
  localparam int unsigned S_HF = 3;
  localparam int unsigned S_HS = 5;
  localparam int unsigned S_HB = 4;
  localparam int unsigned S_VF = 2;
  localparam int unsigned S_VS = 3;
  localparam int unsigned S_VB = 4;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic       se;
    logic [9:0] x;
    logic [8:0] y;
  } obs_t;

  logic clk25;
  logic reset;

  logic       d_hs, d_vs, d_act, d_se;
  logic [9:0] d_x;
  logic [8:0] d_y;
  logic       n_hs, n_vs, n_act, n_se;
  logic [9:0] n_x;
  logic [8:0] n_y;
  logic       p_hs, p_vs, p_act, p_se;
  logic [9:0] p_x;
  logic [8:0] p_y;

  obs_t obs_d, obs_n, obs_p;
  assign obs_d = {d_hs, d_vs, d_act, d_se, d_x, d_y};
  assign obs_n = {n_hs, n_vs, n_act, n_se, n_x, n_y};
  assign obs_p = {p_hs, p_vs, p_act, p_se, p_x, p_y};

  vga_timing_core u_dflt (
    .clk25    (clk25),
    .reset    (reset),
    .hSync    (d_hs),
    .vSync    (d_vs),
    .active   (d_act),
    .screenEnd(d_se),
    .x        (d_x),
    .y        (d_y)
  );

  vga_timing_core #(
    .WIDTH(S_W), .HEIGHT(S_H), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB), .SYNC_POL(1'b0)
  ) u_small_n (
    .clk25    (clk25),
    .reset    (reset),
    .hSync    (n_hs),
    .vSync    (n_vs),
    .active   (n_act),
    .screenEnd(n_se),
    .x        (n_x),
    .y        (n_y)
  );

  vga_timing_core #(
    .WIDTH(S_W), .HEIGHT(S_H), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB), .SYNC_POL(1'b1)
  ) u_small_p (
    .clk25    (clk25),
    .reset    (reset),
    .hSync    (p_hs),
    .vSync    (p_vs),
    .active   (p_act),
    .screenEnd(p_se),
    .x        (p_x),
    .y        (p_y)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  int unsigned t;        // cycles since the last reset release
  int          passed;
  int          total;
  int          hs_low;
  int          hs_first;
  int          vs_low;
  int          se_q[$];

  // Raster position follows directly from elapsed cycles: t mod line, (t / line) mod frame.
  function automatic obs_t model(input bit rst, input int unsigned tc,
                                 input int unsigned w, input int unsigned h,
                                 input int unsigned hf, input int unsigned hs,
                                 input int unsigned hb, input int unsigned vf,
                                 input int unsigned vs, input int unsigned vb,
                                 input bit pol);
    obs_t o;
    int unsigned ht, vt, hc, vc;
    o = '0;
    o.hs = ~pol;
    o.vs = ~pol;
    if (rst) return o;
    ht = w + hf + hs + hb;
    vt = h + vf + vs + vb;
    hc = tc % ht;
    vc = (tc / ht) % vt;
    o.act = (hc < w) && (vc < h);
    o.hs  = (hc >= w + hf && hc < w + hf + hs) ? pol : ~pol;
    o.vs  = (vc >= h + vf && vc < h + vf + vs) ? pol : ~pol;
    o.se  = (hc == 0) && (vc == h);
    o.x   = 10'((hc < w) ? hc : w - 1);
    o.y   = 9'((vc < h) ? vc : h - 1);
    return o;
  endfunction

  task automatic chk(input string tag, input obs_t got, input obs_t exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s rst=%0b t=%0d observed=%h expected=%h", tag, reset, t, got, exp);
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
  endtask

  // Check the current cycle, then advance one clock and drive the next reset level.
  task automatic cycle(input bit next_rst);
    @(negedge clk25);
    chk("dflt", obs_d, model(reset, t, 640, 480, 16, 96, 48, 10, 2, 33, 1'b0));
    chk("small_n", obs_n, model(reset, t, S_W, S_H, S_HF, S_HS, S_HB, S_VF, S_VS, S_VB, 1'b0));
    chk("small_p", obs_p, model(reset, t, S_W, S_H, S_HF, S_HS, S_HB, S_VF, S_VS, S_VB, 1'b1));
    if (!reset) begin
      if (t < 800 && d_hs == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(t);
      end
      if (n_vs == 1'b0) vs_low++;
      if (n_se) se_q.push_back(int'(t));
    end
    @(posedge clk25);
    #1;
    if (reset) t = 0;
    else t++;
    reset = next_rst;
  endtask

  task automatic clear_stats();
    hs_low   = 0;
    hs_first = -1;
    vs_low   = 0;
    se_q.delete();
  endtask

  initial begin
    int n;
    int len;
    passed = 0;
    total  = 0;
    t      = 0;
    reset  = 1'b1;
    clear_stats();

    // Reset held for five cycles, then released.
    repeat (4) cycle(1'b1);
    cycle(1'b0);

    // Three default lines (several reduced frames) uninterrupted from release.
    clear_stats();
    repeat (2400) cycle(1'b0);
    chk_int("hsync_low_len", hs_low, 96);
    chk_int("hsync_start", hs_first, 656);
    // Frames start at 0, 672, 1344; each has 3 sync lines of 32 cycles.
    chk_int("vsync_low_cycles", vs_low, 288);
    chk_int("frame_end_count", se_q.size(), 3);
    if (se_q.size() == 3) begin
      chk_int("frame_end_first", se_q[0], 384);
      chk_int("frame_end_gap0", se_q[1] - se_q[0], 672);
      chk_int("frame_end_gap1", se_q[2] - se_q[1], 672);
    end

    // Random reset pulses of 1..3 cycles at random raster positions.
    for (int i = 0; i < 25; i++) begin
      n   = int'($urandom_range(1, 1200));
      len = int'($urandom_range(1, 3));
      repeat (n - 1) cycle(1'b0);
      cycle(1'b1);
      repeat (len - 1) cycle(1'b1);
      cycle(1'b0);
    end

    // One-cycle reset at reduced line 5, pixel 10; next frame end 384 cycles later.
    repeat (169) cycle(1'b0);
    cycle(1'b1);
    cycle(1'b0);
    clear_stats();
    repeat (700) cycle(1'b0);
    chk_int("restart_frame_end_count", se_q.size(), 1);
    if (se_q.size() >= 1) chk_int("restart_frame_end_at", se_q[0], 384);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
